// File: rtl/ysyx_22050710_ifu_pkg.sv
// Shared IFU definitions: FSM state encodings, next-PC select, reset PC default and instruction width.
package ysyx_22050710_ifu_pkg;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int          INST_W           = 32;
  localparam logic [63:0] PC_STEP          = 64'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;
endpackage

// File: rtl/ysyx_22050710_ifu_pc_reg.sv
// 64-bit program counter with async reset to RESET_PC and hold / +4 / redirect next-PC mux.
module ysyx_22050710_ifu_pc_reg
  import ysyx_22050710_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  pc_sel_e     pc_sel,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc
);
  logic [63:0] pc_next;

  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_INC:      pc_next = pc + PC_STEP;
      PC_REDIRECT: pc_next = redirect_pc;
      default:     pc_next = pc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pc <= RESET_PC;
    else          pc <= pc_next;
  end
endmodule

// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: one outstanding imem fetch, valid/ready toward decode, redirect squashing.
// Optional misaligned-PC marker when YSYX_22050710_IFU_MISALIGN_CHECK_EN is defined.
//
// state  | meaning
// S_IDLE | one cycle after reset before the first fetch
// S_REQ  | request pc on imem, waiting for gnt
// S_WAIT | request granted, waiting for rvalid (drop=1: response is wrong-path)
// S_OUT  | {o_pc, o_inst} presented to decode, waiting for i_ready
module ysyx_22050710_ifu
  import ysyx_22050710_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_redirect,
  input  logic [63:0]       i_redirect_pc,
  output logic              o_imem_req,
  output logic [63:0]       o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [63:0]       o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_misalign
);
  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [63:0] pc;
  pc_sel_e     pc_sel;
  logic        load_out, load_mis;
  logic        misalign_hit;

`ifdef YSYX_22050710_IFU_MISALIGN_CHECK_EN
  assign misalign_hit = (pc[1:0] != 2'b00);
`else
  assign misalign_hit = 1'b0;
`endif

  ysyx_22050710_ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .pc_sel      (pc_sel),
    .redirect_pc (i_redirect_pc),
    .pc          (pc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    pc_sel   = PC_HOLD;
    load_out = 1'b0;
    load_mis = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misalign_hit) begin
          load_mis = 1'b1;
          state_d  = S_OUT;
        end else if (i_imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            load_out = 1'b1;
            state_d  = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (i_ready) begin
          pc_sel  = PC_INC;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides everything above; an in-flight fetch must still be drained.
    if (i_redirect) begin
      pc_sel   = PC_REDIRECT;
      load_out = 1'b0;
      load_mis = 1'b0;
      case (state_q)
        S_REQ: begin
          if (i_imem_gnt && !misalign_hit) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc   <= RESET_PC;
      o_inst <= '0;
    end else if (load_out) begin
      o_pc   <= pc;
      o_inst <= i_imem_rdata;
    end else if (load_mis) begin
      o_pc   <= pc;
      o_inst <= '0;
    end
  end

`ifdef YSYX_22050710_IFU_MISALIGN_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      o_misalign <= 1'b0;
    else if (load_out) o_misalign <= 1'b0;
    else if (load_mis) o_misalign <= 1'b1;
  end
`else
  assign o_misalign = 1'b0;
`endif

  assign o_imem_req  = (state_q == S_REQ) && !misalign_hit;
  assign o_imem_addr = pc;
  assign o_valid     = (state_q == S_OUT);
endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Self-checking bench for ysyx_22050710_ifu: imem model with scoreboarded fetch addresses and decode outputs.
module tb_ysyx_22050710_ifu;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] STALE  = 64'h0000_0000_8000_2004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic        ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        misalign;

  ysyx_22050710_ifu dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_pc          (out_pc),
    .o_inst        (out_inst),
    .o_misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } out_t;

  out_t        exp_out[$];
  logic [63:0] exp_addr[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_hs = -1;
  bit          cad_en = 1'b0;
  bit          gnt_en = 1'b0;
  int          lat = 1;
  int          n_grants = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    if (a == STALE) return 32'hDEAD_BEEF;
    return a[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // imem model: gnt decided at negedge, response lat cycles after the grant edge
  initial begin : imem_model
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [63:0] pend_addr = '0;
    logic [63:0] gnt_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        continue;
      end
      if (imem_gnt) begin
        pend = 1'b1; pend_addr = gnt_addr; cnt = lat;
      end
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_fn(pend_addr); pend = 1'b0;
        end
      end
      imem_gnt = imem_req && gnt_en && !pend;
      if (imem_gnt) begin
        gnt_addr = imem_addr;
        n_grants++;
        if (exp_addr.size() == 0) chk("addr_unexpected", 64'(exp_addr.size()), 64'd1);
        else                      chk("imem_addr", imem_addr, exp_addr.pop_front());
      end
    end
  end

  initial begin : out_monitor
    out_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid && ready && !redirect) begin
        if (exp_out.size() == 0) begin
          chk("out_unexpected", 64'(exp_out.size()), 64'd1);
        end else begin
          e = exp_out.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", 64'(out_inst), 64'(e.inst));
          chk("out_mis", 64'(misalign), 64'(e.mis));
        end
        if (cad_en && last_hs >= 0) chk("cadence", 64'(cyc - last_hs), 64'd3);
        last_hs = cyc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [63:0] a);
    out_t e;
    e.pc = a; e.inst = mem_fn(a); e.mis = 1'b0;
    exp_addr.push_back(a);
    exp_out.push_back(e);
  endtask

  task automatic wait_out_empty(input string tag, input int lim);
    int n = 0;
    while (exp_out.size() != 0 && n < lim) begin step(); n++; end
    chk(tag, 64'(exp_out.size() == 0), 64'd1);
  endtask

  task automatic wait_addr_empty(input string tag, input int lim);
    int n = 0;
    while (exp_addr.size() != 0 && n < lim) begin step(); n++; end
    chk(tag, 64'(exp_addr.size() == 0), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int n = 0;
    while (!valid && n < lim) begin step(); n++; end
    chk(tag, 64'(valid), 64'd1);
  endtask

  initial begin : main
    int   g0;
    out_t e;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    repeat (3) step();

    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_pc", out_pc, RST_PC);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_mis", 64'(misalign), 64'd0);
    chk("rst_addr", imem_addr, RST_PC);

    // 1: zero-wait streaming
    push_fetch(RST_PC);
    push_fetch(RST_PC + 64'd4);
    push_fetch(RST_PC + 64'd8);
    gnt_en = 1'b1; ready = 1'b1; cad_en = 1'b1;
    rst_n = 1'b1;
    wait_out_empty("t1_done", 40);
    gnt_en = 1'b0; cad_en = 1'b0;

    // 2: decode stalls in S_OUT
    ready = 1'b0;
    exp_addr.push_back(RST_PC + 64'hC);
    gnt_en = 1'b1;
    wait_valid("t2_valid_wait", 20);
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 64'(valid), 64'd1);
      chk("t2_pc", out_pc, RST_PC + 64'hC);
      chk("t2_inst", 64'(out_inst), 64'(mem_fn(RST_PC + 64'hC)));
      chk("t2_req", 64'(imem_req), 64'd0);
      step();
    end

    // 4: redirect together with i_ready in S_OUT
    redirect = 1'b1; redirect_pc = 64'h8000_2000; ready = 1'b1;
    step();
    redirect = 1'b0; ready = 1'b0;
    chk("t4_valid", 64'(valid), 64'd0);
    chk("t4_req", 64'(imem_req), 64'd1);
    chk("t4_addr", imem_addr, 64'h8000_2000);
    push_fetch(64'h8000_2000);
    gnt_en = 1'b1; ready = 1'b1;
    wait_out_empty("t4_done", 20);
    gnt_en = 1'b0;

    // 3: redirect in S_WAIT, stale response two cycles later
    lat = 3;
    exp_addr.push_back(STALE);
    gnt_en = 1'b1;
    wait_addr_empty("t3_gnt", 20);
    gnt_en = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect = 1'b0; lat = 1;
    push_fetch(64'h8000_1000);
    gnt_en = 1'b1; ready = 1'b1;
    wait_out_empty("t3_done", 30);
    gnt_en = 1'b0;
    chk("t3_inst", 64'(out_inst), 64'(mem_fn(64'h8000_1000)));

    // 5: gnt held low
    for (int i = 0; i < 4; i++) begin
      chk("t5_req", 64'(imem_req), 64'd1);
      chk("t5_addr", imem_addr, 64'h8000_1004);
      step();
    end
    g0 = n_grants;
    push_fetch(64'h8000_1004);
    gnt_en = 1'b1;
    wait_out_empty("t5_done", 20);
    gnt_en = 1'b0;
    chk("t5_grants", 64'(n_grants - g0), 64'd1);

    // 6: misaligned redirect target
    redirect = 1'b1; redirect_pc = 64'h8000_0002;
    step();
    redirect = 1'b0;
`ifdef YSYX_22050710_IFU_MISALIGN_CHECK_EN
    e.pc = 64'h8000_0002; e.inst = 32'h0; e.mis = 1'b1;
    exp_out.push_back(e);
    chk("t6_req", 64'(imem_req), 64'd0);
    ready = 1'b1;
    wait_out_empty("t6_done", 20);
    chk("t6_req_after", 64'(imem_req), 64'd0);
`else
    chk("t6_req", 64'(imem_req), 64'd1);
    chk("t6_addr", imem_addr, 64'h8000_0002);
    push_fetch(64'h8000_0002);
    gnt_en = 1'b1; ready = 1'b1;
    wait_out_empty("t6_done", 20);
    gnt_en = 1'b0;
    chk("t6_mis", 64'(misalign), 64'd0);
`endif
    ready = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
